// File: rtl/alu_sequencer_if.sv
// Fetch handshake and ALU control bundle; master is the sequencer, slave is memory/datapath.
// Handshake: instr_req is held with a stable instr_addr until instr_ack; alu_finish completes a program.
interface alu_sequencer_if #(
  parameter int ADDR_LEN    = 8,
  parameter int INS_LEN     = 16,
  parameter int ALU_SIG_LEN = 3
);
  logic                   instr_req;
  logic [ADDR_LEN-1:0]    instr_addr;
  logic                   instr_ack;
  logic [INS_LEN-1:0]     instr_data;
  logic [ALU_SIG_LEN-1:0] alu_select;
  logic                   alu_z_flag;
  logic                   alu_finish;
  logic                   acc_wr_en;

  modport master (
    output instr_req, instr_addr, alu_select, acc_wr_en,
    input  instr_ack, instr_data, alu_z_flag, alu_finish
  );

  modport slave (
    input  instr_req, instr_addr, alu_select, acc_wr_en,
    output instr_ack, instr_data, alu_z_flag, alu_finish
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU control sequencer: 3 cycles per ALU op, 2 per NOP/jump, +1 per ack wait; holds req until ack.
// Optional ALU_SEQ_WATCHDOG_EN bounds ack/finish waits and flags error; otherwise waits are unbounded.
module alu_sequencer #(
  parameter int ADDR_LEN    = 8,
  parameter int INS_LEN     = 16,
  parameter int ALU_SIG_LEN = 3,
  parameter int WD_LEN      = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  alu_sequencer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            error
);
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_PASSA = 4'h4;
  localparam logic [3:0] OP_PASSB = 4'h5;
  localparam logic [3:0] OP_CLR   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_END   = 4'hF;

  localparam logic [ALU_SIG_LEN-1:0] SEL_ADD   = ALU_SIG_LEN'(0);
  localparam logic [ALU_SIG_LEN-1:0] SEL_SUB   = ALU_SIG_LEN'(1);
  localparam logic [ALU_SIG_LEN-1:0] SEL_MUL   = ALU_SIG_LEN'(2);
  localparam logic [ALU_SIG_LEN-1:0] SEL_PASSA = ALU_SIG_LEN'(3);
  localparam logic [ALU_SIG_LEN-1:0] SEL_PASSB = ALU_SIG_LEN'(4);
  localparam logic [ALU_SIG_LEN-1:0] SEL_CLR   = ALU_SIG_LEN'(5);
  localparam logic [ALU_SIG_LEN-1:0] SEL_END   = ALU_SIG_LEN'(6);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_FINWAIT, S_HALT
  } state_t;

  state_t                 state;
  logic [ADDR_LEN-1:0]    pc;
  logic [INS_LEN-1:0]     ir;
  logic                   z;
  logic [ALU_SIG_LEN-1:0] sel;
  logic [3:0]             opcode;
  logic [ADDR_LEN-1:0]    target;
  logic                   wd_timeout;
  logic                   unused_ir;

  assign opcode    = ir[INS_LEN-1:INS_LEN-4];
  assign target    = ir[ADDR_LEN-1:0];
  assign unused_ir = ^ir[INS_LEN-5:ADDR_LEN];

`ifdef ALU_SEQ_WATCHDOG_EN
  // Expiry fires on the cycle the count would reach all-ones, i.e. the (2^WD_LEN-1)th wait cycle.
  localparam logic [WD_LEN-1:0] WD_LAST = WD_LEN'((1 << WD_LEN) - 2);
  logic [WD_LEN-1:0] wd_cnt;
  logic              waiting;
  logic              err_q;

  assign waiting    = (state == S_FETCH   && !bus.instr_ack) ||
                      (state == S_FINWAIT && !bus.alu_finish);
  assign wd_timeout = waiting && (wd_cnt == WD_LAST);
  assign error      = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_FETCH || state == S_FINWAIT) wd_cnt <= wd_cnt + WD_LEN'(1);
      else                                        wd_cnt <= '0;
      if (wd_timeout) err_q <= 1'b1;
    end
  end
`else
  logic [WD_LEN-1:0] unused_wd;
  assign unused_wd  = '0;
  assign wd_timeout = 1'b0;
  assign error      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      z     <= 1'b0;
      sel   <= SEL_PASSA;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pc    <= '0;
          z     <= 1'b0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.instr_ack) begin
            ir    <= bus.instr_data;
            state <= S_DECODE;
          end else if (wd_timeout) begin
            state <= S_HALT;
          end
        end
        S_DECODE: begin
          state <= S_FETCH;
          case (opcode)
            OP_ADD:   begin sel <= SEL_ADD;   state <= S_EXEC; end
            OP_SUB:   begin sel <= SEL_SUB;   state <= S_EXEC; end
            OP_MUL:   begin sel <= SEL_MUL;   state <= S_EXEC; end
            OP_PASSA: begin sel <= SEL_PASSA; state <= S_EXEC; end
            OP_PASSB: begin sel <= SEL_PASSB; state <= S_EXEC; end
            OP_CLR:   begin sel <= SEL_CLR;   state <= S_EXEC; end
            OP_JZ:    pc <= z ? target : pc + ADDR_LEN'(1);
            OP_JMP:   pc <= target;
            OP_END:   begin sel <= SEL_END;   state <= S_FINWAIT; end
            default:  pc <= pc + ADDR_LEN'(1);
          endcase
        end
        S_EXEC: begin
          // The ALU only refreshes its zero flag for add/sub.
          if (opcode == OP_ADD || opcode == OP_SUB) z <= bus.alu_z_flag;
          pc    <= pc + ADDR_LEN'(1);
          state <= S_FETCH;
        end
        S_FINWAIT: if (bus.alu_finish || wd_timeout) state <= S_HALT;
        S_HALT:    if (!start) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_req  = (state == S_FETCH);
  assign bus.instr_addr = pc;
  assign bus.alu_select = sel;
  assign bus.acc_wr_en  = (state == S_EXEC);
  assign busy           = (state != S_IDLE) && (state != S_HALT);
  assign done           = (state == S_HALT);
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instruction memory array, per-cycle responder, inline checks.
module tb_alu_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, busy, done, error;
  alu_sequencer_if #(.ADDR_LEN(8), .INS_LEN(16), .ALU_SIG_LEN(3)) bus ();

  alu_sequencer #(.ADDR_LEN(8), .INS_LEN(16), .ALU_SIG_LEN(3), .WD_LEN(4)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error)
  );

  logic [15:0] mem [256];
  int          n_pass, n_total, cyc;
  logic        auto_ack, sub_z;
  logic [7:0]  fetch_addr [16];
  int          fetch_cyc [16];
  int          n_fetch, n_acc, done_cyc;
  int          acc_cyc [4];
  logic [2:0]  acc_sel [4];
  logic [2:0]  done_sel;
  bit          halted;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_ack) bus.instr_ack = 1'b1;
    bus.instr_data = mem[bus.instr_addr];
    bus.alu_z_flag = (bus.alu_select == 3'b001) ? sub_z : 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    start = 1'b0;
    bus.instr_ack = 1'b0;
    bus.alu_finish = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  // Runs from IDLE (start already 1) logging fetches, accumulator strobes and completion.
  task automatic run_prog(input int max_cyc, input int max_fetch, output bit halt_seen);
    halt_seen = 1'b0;
    n_fetch = 0; n_acc = 0; done_cyc = -1; cyc = 0; done_sel = 3'b000;
    for (int i = 0; i < 16; i++) begin fetch_addr[i] = 8'h00; fetch_cyc[i] = 0; end
    for (int i = 0; i < 4; i++) begin acc_cyc[i] = 0; acc_sel[i] = 3'b000; end
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (bus.instr_req && n_fetch < 16) begin
        fetch_addr[n_fetch] = bus.instr_addr;
        fetch_cyc[n_fetch] = cyc;
        n_fetch++;
      end
      if (bus.acc_wr_en && n_acc < 4) begin
        acc_cyc[n_acc] = cyc;
        acc_sel[n_acc] = bus.alu_select;
        n_acc++;
      end
      if (done) begin
        halt_seen = 1'b1; done_cyc = cyc; done_sel = bus.alu_select;
        break;
      end
      if (n_fetch >= max_fetch) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({bus.instr_req, bus.acc_wr_en, busy, done, error} !== 5'b00000)
      $display("FAIL reset_flags got=%b exp=00000", {bus.instr_req, bus.acc_wr_en, busy, done, error});
    else n_pass++;
    n_total++;
    if (bus.alu_select !== 3'b011) $display("FAIL reset_select got=%b exp=011", bus.alu_select);
    else n_pass++;
    n_total++;
    if (bus.instr_addr !== 8'h00) $display("FAIL reset_addr got=%h exp=00", bus.instr_addr);
    else n_pass++;
    reset = 1'b1;
    step();
    step();
    n_total++;
    if ({busy, bus.instr_req} !== 2'b00) $display("FAIL idle_no_start got=%b exp=00", {busy, bus.instr_req});
    else n_pass++;
  endtask

  task automatic test_program();
    clear_mem();
    mem[0] = 16'h4000; mem[1] = 16'h1000; mem[2] = 16'hF000;
    auto_ack = 1'b1; bus.alu_finish = 1'b1; start = 1'b1;
    run_prog(30, 99, halted);
    n_total++;
    if (!halted || done_cyc != 10) $display("FAIL prog_done_cycle got=%0d exp=10", done_cyc);
    else n_pass++;
    n_total++;
    if (n_acc != 2) $display("FAIL prog_acc_count got=%0d exp=2", n_acc);
    else n_pass++;
    n_total++;
    if (acc_cyc[0] != 3 || acc_cyc[1] != 6)
      $display("FAIL prog_acc_cycles got=%0d,%0d exp=3,6", acc_cyc[0], acc_cyc[1]);
    else n_pass++;
    n_total++;
    if ({acc_sel[0], acc_sel[1], done_sel} !== 9'b011_000_110)
      $display("FAIL prog_select_seq got=%b,%b,%b exp=011,000,110", acc_sel[0], acc_sel[1], done_sel);
    else n_pass++;
    n_total++;
    if (n_fetch != 3 || {fetch_addr[0], fetch_addr[1], fetch_addr[2]} !== 24'h000102)
      $display("FAIL prog_fetch_addrs got=%0d:%h%h%h exp=3:000102", n_fetch, fetch_addr[0], fetch_addr[1], fetch_addr[2]);
    else n_pass++;
    step();
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL halt_hold_start got=%b%b exp=10", done, busy);
    else n_pass++;
    start = 1'b0;
    step();
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL halt_to_idle got=%b exp=00", {done, busy});
    else n_pass++;
  endtask

  task automatic test_jz();
    auto_ack = 1'b1; bus.alu_finish = 1'b1;
    // SUB z=1, MUL leaves z, JZ taken
    clear_mem();
    mem[0] = 16'h2000; mem[1] = 16'h3000; mem[2] = 16'h7020; mem[8'h20] = 16'hF000;
    sub_z = 1'b1; start = 1'b1;
    run_prog(40, 99, halted);
    start = 1'b0; step();
    n_total++;
    if (!halted || n_fetch != 4 || {fetch_addr[0], fetch_addr[1], fetch_addr[2], fetch_addr[3]} !== 32'h00010220)
      $display("FAIL jz_taken got=%0d:%h%h%h%h exp=4:00010220", n_fetch,
               fetch_addr[0], fetch_addr[1], fetch_addr[2], fetch_addr[3]);
    else n_pass++;
    // z from the previous run must be cleared on start
    clear_mem();
    mem[0] = 16'h7040; mem[1] = 16'hF000; mem[8'h40] = 16'hF000;
    start = 1'b1;
    run_prog(40, 99, halted);
    start = 1'b0; step();
    n_total++;
    if (!halted || n_fetch != 2 || fetch_addr[1] !== 8'h01)
      $display("FAIL z_clear_on_start got=%0d:%h exp=2:01", n_fetch, fetch_addr[1]);
    else n_pass++;
    // SUB z=0, JZ falls through, undefined opcode acts as NOP
    clear_mem();
    mem[0] = 16'h2000; mem[1] = 16'h3000; mem[2] = 16'h7020; mem[3] = 16'hA000;
    mem[4] = 16'hF000; mem[8'h20] = 16'hF000;
    sub_z = 1'b0; start = 1'b1;
    run_prog(40, 99, halted);
    start = 1'b0; step();
    n_total++;
    if (!halted || n_fetch != 5 || {fetch_addr[0], fetch_addr[1], fetch_addr[2], fetch_addr[3], fetch_addr[4]} !== 40'h0001020304)
      $display("FAIL jz_not_taken got=%0d:%h%h%h%h%h exp=5:0001020304", n_fetch,
               fetch_addr[0], fetch_addr[1], fetch_addr[2], fetch_addr[3], fetch_addr[4]);
    else n_pass++;
    n_total++;
    if (fetch_cyc[4] != 11) $display("FAIL op_latency got=%0d exp=11", fetch_cyc[4]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 16'h80FF; mem[8'hFF] = 16'h0000;
    auto_ack = 1'b1; bus.alu_finish = 1'b0; start = 1'b1;
    run_prog(40, 4, halted);
    n_total++;
    if (n_fetch != 4 || {fetch_addr[0], fetch_addr[1], fetch_addr[2], fetch_addr[3]} !== 32'h00FF00FF)
      $display("FAIL pc_wrap got=%0d:%h%h%h%h exp=4:00FF00FF", n_fetch,
               fetch_addr[0], fetch_addr[1], fetch_addr[2], fetch_addr[3]);
    else n_pass++;
    n_total++;
    if (fetch_cyc[3] != 7) $display("FAIL jump_latency got=%0d exp=7", fetch_cyc[3]);
    else n_pass++;
    pulse_reset();
  endtask

  task automatic test_ack_delay();
    int   hold;
    logic addr_bad;
    clear_mem();
    mem[0] = 16'hF000;
    auto_ack = 1'b0; bus.instr_ack = 1'b0; bus.alu_finish = 1'b0;
    start = 1'b1; cyc = 0;
    step();
    hold = 0; addr_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.instr_req) break;
      hold++;
      if (bus.instr_addr !== 8'h00) addr_bad = 1'b1;
      bus.instr_ack = (hold == 5);
      step();
    end
    bus.instr_ack = 1'b0;
    n_total++;
    if (hold != 5) $display("FAIL req_hold_cycles got=%0d exp=5", hold);
    else n_pass++;
    n_total++;
    if (addr_bad !== 1'b0) $display("FAIL addr_stable got=%b exp=0", addr_bad);
    else n_pass++;
    n_total++;
    if (cyc != 6 || busy !== 1'b1) $display("FAIL decode_after_ack got=%0d/%b exp=6/1", cyc, busy);
    else n_pass++;
    step();
    n_total++;
    if (bus.alu_select !== 3'b110 || bus.instr_req !== 1'b0 || done !== 1'b0)
      $display("FAIL finwait_select got=%b exp=110", bus.alu_select);
    else n_pass++;
    bus.alu_finish = 1'b1;
    step();
    n_total++;
    if (done !== 1'b1) $display("FAIL finish_to_halt got=%b exp=1", done);
    else n_pass++;
    bus.alu_finish = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h1000;
    auto_ack = 1'b1; bus.alu_finish = 1'b0; start = 1'b1; cyc = 0;
    for (int i = 0; i < 5; i++) step();
    n_total++;
    if (bus.acc_wr_en !== 1'b1 || bus.alu_select !== 3'b000 || bus.instr_addr !== 8'h01)
      $display("FAIL exec_precond got=%b/%b/%h exp=1/000/01", bus.acc_wr_en, bus.alu_select, bus.instr_addr);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({bus.acc_wr_en, busy, bus.instr_req, done, error, bus.alu_select, bus.instr_addr} !== {5'b00000, 3'b011, 8'h00})
      $display("FAIL reset_mid_exec got=%b%b%b%b%b/%b/%h exp=00000/011/00", bus.acc_wr_en, busy,
               bus.instr_req, done, error, bus.alu_select, bus.instr_addr);
    else n_pass++;
    reset = 1'b1;
    auto_ack = 1'b0; bus.instr_ack = 1'b0;
    step();
    n_total++;
    if (bus.instr_req !== 1'b1 || bus.instr_addr !== 8'h00)
      $display("FAIL restart_addr got=%b/%h exp=1/00", bus.instr_req, bus.instr_addr);
    else n_pass++;
    step();
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({bus.instr_req, busy} !== 2'b00) $display("FAIL reset_mid_fetch got=%b exp=00", {bus.instr_req, busy});
    else n_pass++;
    reset = 1'b1; start = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    int bad;
    clear_mem();
    auto_ack = 1'b0; bus.instr_ack = 1'b0; bus.alu_finish = 1'b0;
    start = 1'b1; cyc = 0;
    step();
`ifdef ALU_SEQ_WATCHDOG_EN
    for (int i = 0; i < 14; i++) step();
    n_total++;
    if ({error, busy} !== 2'b01) $display("FAIL wd_before_expiry got=%b exp=01", {error, busy});
    else n_pass++;
    step();
    n_total++;
    if ({error, done, busy} !== 3'b110) $display("FAIL wd_expiry got=%b exp=110", {error, done, busy});
    else n_pass++;
    start = 1'b0;
    step();
    n_total++;
    if ({error, done} !== 2'b10) $display("FAIL wd_error_sticky got=%b exp=10", {error, done});
    else n_pass++;
`else
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1 || bus.instr_req !== 1'b1 || error !== 1'b0 || done !== 1'b0) bad++;
      step();
    end
    n_total++;
    if (bad != 0) $display("FAIL unbounded_wait got=%0d bad cycles exp=0", bad);
    else n_pass++;
`endif
    pulse_reset();
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; auto_ack = 1'b0; sub_z = 1'b0;
    bus.instr_ack = 1'b0; bus.instr_data = 16'h0000;
    bus.alu_z_flag = 1'b0; bus.alu_finish = 1'b0;
    clear_mem();
    test_reset();
    test_program();
    test_jz();
    test_wrap();
    test_ack_delay();
    test_async_reset();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
